// File: rtl/hyperspace_io_stream.sv
// Pin-level stream reducer: packs 8-bit samples into 4-byte pixels and emits
// the three adjacent-band 16-bit sums of each pixel over a valid/ready/last port.
module hyperspace_io_stream #(
  parameter int IO_W  = 38,
  parameter int GROUP = 4
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  localparam int IDX_W = $clog2(GROUP);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(GROUP - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(GROUP - 2);
  // Pins 0-17 and 27 are driven outputs; everything else stays an input.
  localparam logic [IO_W-1:0] OUT_PINS = IO_W'(38'h00_0803_FFFF);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] widx;
  logic             last_flag;
  logic [7:0]       b  [GROUP];
  logic [7:0]       nb [GROUP];
  logic             in_ready;
  logic             out_valid;
  logic             out_last;
  logic [15:0]      out_data;

  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [7:0] in_byte;
  logic       accept;
  logic       group_done;
  logic       unused_pins;

  assign out_ready   = io_in[18];
  assign in_valid    = io_in[28];
  assign in_last     = io_in[29];
  assign unused_pins = ^{io_in[17:0], io_in[27:19]};

  // The byte arrives on the pads LSB-first from pin 37 downwards.
  always_comb begin
    for (int i = 0; i < 8; i++) in_byte[i] = io_in[37-i];
  end

  assign accept     = (state == COLLECT) && in_ready && in_valid;
  assign group_done = accept && (in_last || idx == LAST_IDX);

  // Byte file as it will look after this accept: earlier bytes kept, the new
  // byte placed at idx, later slots zeroed so a short group is already padded.
  // NOTE: every branch assigns nb[i], so this stays combinational with no latch.
  always_comb begin
    for (int i = 0; i < GROUP; i++) begin
      if (i < int'(idx))       nb[i] = b[i];
      else if (i == int'(idx)) nb[i] = in_byte;
      else                     nb[i] = 8'h00;
    end
  end

  function automatic logic [15:0] pair_sum(input logic [7:0] x, input logic [7:0] y);
    return {7'd0, {1'b0, x} + {1'b0, y}};
  endfunction

  // NOTE: state is updated with non-blocking assignments only, so every read
  // below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state     <= COLLECT;
      idx       <= '0;
      widx      <= '0;
      last_flag <= 1'b0;
      // NOTE: the byte file is only four registers, so it is reset like any
      // other flop to keep X out of the sums.
      for (int i = 0; i < GROUP; i++) b[i] <= 8'h00;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 16'h0000;
    end else if (state == COLLECT) begin
      in_ready <= 1'b1;
      if (accept) begin
        b   <= nb;
        idx <= idx + IDX_W'(1);
        if (in_last) last_flag <= 1'b1;
        if (group_done) begin
          state     <= EMIT;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          out_data  <= pair_sum(nb[0], nb[1]);
          widx      <= '0;
        end
      end
    end else if (out_ready) begin
      if (widx == LAST_WORD) begin
        state     <= COLLECT;
        idx       <= '0;
        widx      <= '0;
        last_flag <= 1'b0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_data  <= 16'h0000;
      end else begin
        widx     <= widx + IDX_W'(1);
        out_data <= pair_sum(b[widx + IDX_W'(1)], b[widx + IDX_W'(2)]);
        out_last <= (widx == LAST_WORD - IDX_W'(1)) && last_flag;
      end
    end
  end

  always_comb begin
    io_out        = '0;
    io_out[15:0]  = out_data;
    io_out[16]    = out_last;
    io_out[17]    = out_valid;
    io_out[27]    = in_ready;
  end

  assign io_oeb = ~OUT_PINS;

endmodule

// File: tb/tb_hyperspace_io_stream.sv
// Bench for hyperspace_io_stream: directed groups plus random frames checked
// against a queue-based model of the pixel-to-band-sum reduction.
module tb_hyperspace_io_stream;

  logic        clock = 1'b0;
  logic        resetb;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  hyperspace_io_stream dut (
    .clock (clock),
    .resetb(resetb),
    .io_in (io_in),
    .io_out(io_out),
    .io_oeb(io_oeb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } word_t;

  localparam logic [37:0] IN_ONLY = 38'h3F_F7FC_0000;

  logic [7:0] stim_byte[$];
  logic       stim_last[$];
  logic [7:0] cur[$];
  word_t      exp_q[$];
  word_t      obs_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] pins(input logic v, input logic l, input logic [7:0] d,
                                       input logic r);
    logic [37:0] p;
    p     = 38'({$urandom(), $urandom()});
    p[18] = r;
    p[28] = v;
    p[29] = l;
    for (int i = 0; i < 8; i++) p[37-i] = d[i];
    return p;
  endfunction

  task automatic add(input logic [7:0] d, input logic l);
    stim_byte.push_back(d);
    stim_last.push_back(l);
  endtask

  task automatic clear_stim();
    stim_byte.delete();
    stim_last.delete();
  endtask

  task automatic random_frame(input int n);
    clear_stim();
    for (int i = 0; i < n; i++) add(8'($urandom), i == n - 1);
  endtask

  // Reference: a pixel is four bytes (zero-padded if cut short by last) and
  // produces p0+p1, p1+p2, p2+p3; the third word carries last.
  task automatic model_accept(input logic [7:0] d, input logic l, output bit done);
    word_t w;
    cur.push_back(d);
    done = 1'b0;
    if (cur.size() == 4 || l) begin
      while (cur.size() < 4) cur.push_back(8'h00);
      for (int k = 0; k < 3; k++) begin
        w.data = 16'(cur[k]) + 16'(cur[k+1]);
        w.last = (k == 2) && l;
        exp_q.push_back(w);
      end
      cur.delete();
      done = 1'b1;
    end
  endtask

  // Cycle loop: sample outputs on the falling edge, choose inputs for the next
  // rising edge, and predict which transfers that edge performs.
  task automatic run(input int vmode, input int rmode, input int stop_at, input int budget);
    int          sent = 0;
    int          cyc  = 0;
    bit          prev_stall = 1'b0;
    bit          done_prev  = 1'b0;
    bit          done;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        v, l, r;
    logic [7:0]  d;
    word_t       w;
    obs_q.delete();
    while (cyc < budget) begin
      if (stop_at >= 0 && sent >= stop_at) break;
      if (stop_at < 0 && sent == stim_byte.size() && exp_q.size() == 0 && cur.size() == 0) break;
      check("pad_zero", io_out & IN_ONLY, 0);
      if (io_out[17]) check("no_accept_in_emit", io_out[27], 0);
      if (prev_stall) begin
        check("stall_valid", io_out[17], 1);
        check("stall_data", io_out[15:0], prev_data);
        check("stall_last", io_out[16], prev_last);
      end
      if (done_prev) check("latency_valid", io_out[17], 1);
      done_prev = 1'b0;

      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
      if (io_out[27]) begin
        v = (sent < stim_byte.size()) && (vmode == 0 || $urandom_range(0, 3) != 0);
        d = v ? stim_byte[sent] : 8'($urandom);
        l = v ? stim_last[sent] : 1'($urandom_range(0, 1));
      end else begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        l = 1'($urandom_range(0, 1));
      end
      io_in = pins(v, l, d, r);

      if (io_out[27] && v) begin
        model_accept(d, l, done);
        done_prev = done;
        sent++;
      end
      if (io_out[17] && r) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("word_data", io_out[15:0], w.data);
          check("word_last", io_out[16], w.last);
        end
        w.data = io_out[15:0];
        w.last = io_out[16];
        obs_q.push_back(w);
      end
      prev_stall = io_out[17] && !r;
      prev_data  = io_out[15:0];
      prev_last  = io_out[16];
      cyc++;
      @(posedge clock);
      @(negedge clock);
    end
    check("run_in_budget", cyc < budget, 1);
    if (stop_at < 0) begin
      check("idle_ready", io_out[27], 1);
      check("idle_valid", io_out[17], 0);
    end
  endtask

  task automatic expect_word(input string tag, input int i, input logic [15:0] data,
                             input logic last);
    check({tag, "_present"}, obs_q.size() > i, 1);
    if (obs_q.size() > i) begin
      check({tag, "_data"}, obs_q[i].data, data);
      check({tag, "_last"}, obs_q[i].last, last);
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    io_in  = pins(1'b1, 1'b1, 8'($urandom), 1'b1);
    @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", io_out[17], 0);
    check("rst_out_last", io_out[16], 0);
    check("rst_out_data", io_out[15:0], 0);
    check("rst_in_ready", io_out[27], 0);
    check("rst_oeb", io_oeb, IN_ONLY);
    cur.delete();
    exp_q.delete();
    resetb = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_ready_rise", io_out[27], 1);
  endtask

  task automatic frame_summary(input string tag, input int words);
    int lasts = 0;
    check({tag, "_words"}, obs_q.size(), words);
    foreach (obs_q[i]) if (obs_q[i].last) lasts++;
    check({tag, "_last_count"}, lasts, 1);
    check({tag, "_last_pos"}, obs_q.size() == words && obs_q[words-1].last, 1);
  endtask

  initial begin
    resetb = 1'b0;
    io_in  = '0;
    @(negedge clock);
    do_reset();

    clear_stim();
    add(8'h01, 1'b0); add(8'h02, 1'b0); add(8'h03, 1'b0); add(8'h04, 1'b0);
    run(0, 0, -1, 200);
    check("inc_words", obs_q.size(), 3);
    expect_word("inc_w0", 0, 16'h0003, 1'b0);
    expect_word("inc_w1", 1, 16'h0005, 1'b0);
    expect_word("inc_w2", 2, 16'h0007, 1'b0);

    clear_stim();
    add(8'hFF, 1'b0); add(8'hFF, 1'b0); add(8'hFF, 1'b0); add(8'hFF, 1'b1);
    run(0, 0, -1, 200);
    check("max_words", obs_q.size(), 3);
    expect_word("max_w0", 0, 16'h01FE, 1'b0);
    expect_word("max_w1", 1, 16'h01FE, 1'b0);
    expect_word("max_w2", 2, 16'h01FE, 1'b1);

    clear_stim();
    add(8'h01, 1'b0); add(8'h00, 1'b0); add(8'h00, 1'b0); add(8'h00, 1'b0);
    run(0, 0, -1, 200);
    expect_word("bitrev_w0", 0, 16'h0001, 1'b0);
    expect_word("bitrev_w1", 1, 16'h0000, 1'b0);
    expect_word("bitrev_w2", 2, 16'h0000, 1'b0);

    clear_stim();
    add(8'h10, 1'b0); add(8'h20, 1'b1);
    run(0, 0, -1, 200);
    check("short_words", obs_q.size(), 3);
    expect_word("short_w0", 0, 16'h0030, 1'b0);
    expect_word("short_w1", 1, 16'h0020, 1'b0);
    expect_word("short_w2", 2, 16'h0000, 1'b1);

    random_frame(24);
    run(1, 1, -1, 2000);
    frame_summary("bp", 18);

    random_frame(2048);
    run(1, 2, -1, 30000);
    frame_summary("frame", 1536);

    random_frame(2048);
    run(1, 2, 1001, 30000);
    do_reset();
    random_frame(64);
    run(1, 2, -1, 2000);
    frame_summary("post_rst", 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperspace_io_stream.md
Name: hyperspace_io_stream

Overview:
- Pin-level streaming block for the user project area.
- Receives an 8-bit sample stream (valid/ready/last) on user I/O pins.
- Groups samples into 4-byte pixels and reduces each pixel to three 16-bit adjacent-band sums.
- Sends the sums out as a 16-bit stream (valid/ready/last) on other user I/O pins.
- A 2048-byte input frame yields a 1536-word output frame.

Parameters:
- IO_W, 38, number of user I/O pins.
- GROUP, 4, input bytes per pixel group (fixed at 4; outputs per group = GROUP-1).

Ports:
- clock   in   1   system clock; all logic on rising edge.
- resetb  in   1   synchronous, active-low reset.
- io_in   in   38  pad inputs.
- io_out  out  38  pad outputs.
- io_oeb  out  38  pad output-enable, active low (0 = drive).

Behaviour:
- Pin map, inputs:
  - io_in[18] = out_ready.
  - io_in[28] = in_valid.
  - io_in[29] = in_last.
  - io_in[37:30] = input byte, bit-reversed: io_in[37] is bit0, io_in[30] is bit7. The block reverses it back.
- Pin map, outputs:
  - io_out[15:0] = out_data.
  - io_out[16] = out_last.
  - io_out[17] = out_valid.
  - io_out[27] = in_ready.
- io_oeb: 0 on pins 0-17 and 27; 1 on all other pins. io_out drives 0 on all non-output pins.
- Reset (resetb=0 at a rising edge):
  - State goes to COLLECT; byte index = 0; word index = 0; last flag cleared; byte registers cleared.
  - out_valid=0, out_last=0, out_data=0, in_ready=0 during reset.
  - Reset mid-frame discards any partial group and any pending words.
- COLLECT:
  - in_ready=1 (registered; it rises the first cycle after reset deasserts).
  - A byte is accepted on a rising edge with in_ready=1 and in_valid=1. It is stored as b[idx] and idx increments.
  - An accepted byte with in_last=1 sets the last flag.
  - Group completes when the 4th byte is accepted, or when a byte with in_last=1 is accepted at idx<3. Unfilled bytes are zero-padded.
  - On completion: next cycle enters EMIT with in_ready=0 and out_valid=1. Latency is 1 cycle from the accepting edge to the first valid word.
- EMIT:
  - Presents words w0=b0+b1, w1=b1+b2, w2=b2+b3.
  - Each word is a 9-bit unsigned sum, zero-extended to 16 bits.
  - out_data and out_valid hold stable until out_ready=1 at a rising edge; the next word then appears the following cycle, with no bubble.
  - out_last=1 only with w2, and only if the last flag is set.
  - After w2 is transferred: clear idx and the last flag, return to COLLECT, and set in_ready=1 the next cycle.
- in_valid=0 in COLLECT: nothing changes.
- out_ready=0 in EMIT: full stall, all outputs hold.
- in_valid and in_last while in_ready=0 are ignored.
- Frame arithmetic: 2048 bytes = 512 groups = 1536 words. out_last is asserted exactly once, on word 1535.
- No X propagation: every register has a reset value.

Test Plan:
- Reset release, out_ready=1, bytes 0x01,0x02,0x03,0x04 with valid -> words 0x0003, 0x0005, 0x0007, out_last=0; in_ready=0 during emit, then 1.
- Bytes 0xFF,0xFF,0xFF,0xFF with in_last on byte 4 -> 0x01FE, 0x01FE, 0x01FE; out_last=1 on the third word only.
- Bit-order check: pin pattern io_in[37:30]=8'b1000_0000 (value 0x80 on pins) decodes to byte 0x01 -> group {0x01,0,0,0} yields 0x0001, 0x0000, 0x0000.
- Short frame: bytes 0x10,0x20 with in_last on 0x20 -> 0x0030, 0x0020, 0x0000; out_last=1 on the third word.
- Backpressure: out_ready toggled 1,0,0,1,... -> every word is transferred exactly once, data is stable while stalled, no bytes are accepted during EMIT.
- Full frame: 2048 random bytes with in_valid gaps, last on byte 2047 -> exactly 1536 words, all matching the reference sums, out_last only on word 1535; resetb pulsed mid-frame -> outputs zero next cycle and a new frame is processed cleanly.
